// File: rtl/gio_edge_capture_if.sv
// Core-side port bus for gio_edge_capture: address/value bus, read and write
// strobes, read data, and the interrupt request/acknowledge pair.
// The core drives the master modport; the capture block uses the slave modport.
interface gio_edge_capture_if;
  logic [7:0] address;
  logic [7:0] value_in;
  logic       wen;
  logic       ren;
  logic [7:0] data_out;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output address, value_in, wen, ren, interrupt_ack,
    input  data_out, interrupt
  );

  modport slave (
    input  address, value_in, wen, ren, interrupt_ack,
    output data_out, interrupt
  );
endinterface

// File: rtl/gio_edge_capture.sv
// gio_edge_capture: synchronizes and debounces WIDTH external pins, latches
// sticky edge flags (cleared by reading ADDR_FLAGS), keeps an interrupt mask,
// and raises an interrupt through an interrupt/interrupt_ack handshake.
// Optional macro GIO_EDGE_FALL_EN: when defined, falling edges of the
// debounced level also set flags; otherwise only rising edges do.
module gio_edge_capture #(
  parameter int         WIDTH      = 4,
  parameter logic [7:0] ADDR_LEVEL = 8'h01,
  parameter logic [7:0] ADDR_FLAGS = 8'h03,
  parameter logic [7:0] ADDR_MASK  = 8'h04,
  parameter int         DEB_CYCLES = 4,
  parameter int         CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] level_out,
  gio_edge_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ASSERT     = 2'd1,
    S_WAIT_CLEAR = 2'd2
  } state_t;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_det;
  logic             flags_clr;
  logic             mask_wr;
  logic             pending;
  state_t           state_q, state_d;

  // Upper value_in bits are not stored when WIDTH < 8.
  logic unused_value_bits;
  assign unused_value_bits = ^bus.value_in;

  // Two-flop synchronizer per pin; sync2_q is the synchronized level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEB_CYCLES consecutive differing clocks.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge detection on the debounced level, evaluated on the clock it changes.
  always_comb begin
`ifdef GIO_EDGE_FALL_EN
    edge_det = stable_d ^ stable_q;
`else
    edge_det = stable_d & ~stable_q;
`endif
  end

  // Bus-side decode: flag clear on read, mask update on write; a new edge wins over clear.
  always_comb begin
    flags_clr = bus.ren && (bus.address == ADDR_FLAGS);
    mask_wr   = bus.wen && (bus.address == ADDR_MASK);
    flags_d   = (flags_clr ? '0 : flags_q) | edge_det;
    mask_d    = mask_wr ? bus.value_in[WIDTH-1:0] : mask_q;
    pending   = |(flags_q & mask_q);
  end

  // Debounce, flag and mask state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      flags_q  <= flags_d;
      mask_q   <= mask_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Interrupt FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupt FSM next state; WAIT_CLEAR blocks re-triggering on an unserviced flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (pending)           state_d = S_ASSERT;
      S_ASSERT:     if (bus.interrupt_ack) state_d = S_WAIT_CLEAR;
      S_WAIT_CLEAR: if (!pending)          state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // Outputs: interrupt decoded from the state register, level and read mux.
  always_comb begin
    bus.interrupt = (state_q == S_ASSERT);
    level_out     = stable_q;
    bus.data_out  = '0;
    if (bus.address == ADDR_LEVEL) begin
      bus.data_out[WIDTH-1:0] = stable_q;
    end else if (bus.address == ADDR_FLAGS) begin
      bus.data_out[WIDTH-1:0] = flags_q;
    end else if (bus.address == ADDR_MASK) begin
      bus.data_out[WIDTH-1:0] = mask_q;
    end
  end

endmodule

// File: tb/tb_gio_edge_capture.sv
// Directed bench for gio_edge_capture (WIDTH=4, DEB_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_gio_edge_capture;

  logic       clk;
  logic       rst;
  logic [3:0] pins_in;
  logic [3:0] level_out;
  int         total_cnt;
  int         pass_cnt;

  gio_edge_capture_if bif ();

  gio_edge_capture #(
    .WIDTH     (4),
    .ADDR_LEVEL(8'h01),
    .ADDR_FLAGS(8'h03),
    .ADDR_MASK (8'h04),
    .DEB_CYCLES(4),
    .CNT_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pins_in  (pins_in),
    .level_out(level_out),
    .bus      (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bif.address = addr;
    #1;
    chk(tag, bif.data_out, exp);
  endtask

  initial begin
    logic [7:0] fall_flag1;
    logic [7:0] fall_flags;
    logic [7:0] fall_irq;
`ifdef GIO_EDGE_FALL_EN
    fall_flag1 = 8'h02;
    fall_flags = 8'h05;
    fall_irq   = 8'h01;
`else
    fall_flag1 = 8'h00;
    fall_flags = 8'h04;
    fall_irq   = 8'h00;
`endif
    total_cnt         = 0;
    pass_cnt          = 0;
    rst               = 1'b0;
    pins_in           = 4'hA;
    bif.address       = 8'h00;
    bif.value_in      = 8'h00;
    bif.wen           = 1'b0;
    bif.ren           = 1'b0;
    bif.interrupt_ack = 1'b0;

    // Reset held with pins at 4'hA.
    step(3);
    chk("rst_level", {4'h0, level_out}, 8'h00);
    chk("rst_irq", {7'h0, bif.interrupt}, 8'h00);
    chk_rd("rst_rd01", 8'h01, 8'h00);
    chk_rd("rst_rd03", 8'h03, 8'h00);
    chk_rd("rst_rd04", 8'h04, 8'h00);

    // Release: level appears 6 clocks later, rising flags on bits 1 and 3.
    rst = 1'b1;
    step(5);
    chk("deb_level_5clk", {4'h0, level_out}, 8'h00);
    step(1);
    chk("deb_level_6clk", {4'h0, level_out}, 8'h0A);
    chk_rd("deb_flags", 8'h03, 8'h0A);
    chk_rd("deb_rd_level", 8'h01, 8'h0A);

    // Clear flags with a read.
    bif.address = 8'h03;
    bif.ren     = 1'b1;
    step(1);
    bif.ren = 1'b0;
    chk_rd("clr_flags", 8'h03, 8'h00);

    // 3-clock glitch on pin0 is rejected.
    pins_in = 4'hB;
    step(3);
    pins_in = 4'hA;
    step(6);
    chk("glitch_level", {4'h0, level_out}, 8'h0A);
    chk_rd("glitch_flags", 8'h03, 8'h00);

    // 4-clock pulse on pin0 is accepted.
    pins_in = 4'hB;
    step(4);
    pins_in = 4'hA;
    step(2);
    chk("pulse_level_hi", {4'h0, level_out}, 8'h0B);
    chk_rd("pulse_flags", 8'h03, 8'h01);
    step(4);
    chk("pulse_level_lo", {4'h0, level_out}, 8'h0A);
    chk("pulse_irq_unmasked", {7'h0, bif.interrupt}, 8'h00);
    bif.address = 8'h03;
    bif.ren     = 1'b1;
    step(1);
    bif.ren = 1'b0;
    chk_rd("pulse_clr", 8'h03, 8'h00);

    // Interrupt handshake on pin0 with mask = 1.
    bif.address  = 8'h04;
    bif.value_in = 8'h01;
    bif.wen      = 1'b1;
    step(1);
    bif.wen = 1'b0;
    chk_rd("mask_rd", 8'h04, 8'h01);
    pins_in = 4'hB;
    step(6);
    chk_rd("hs_flag", 8'h03, 8'h01);
    chk("hs_irq_pre", {7'h0, bif.interrupt}, 8'h00);
    step(1);
    chk("hs_irq_set", {7'h0, bif.interrupt}, 8'h01);
    step(2);
    chk("hs_irq_hold", {7'h0, bif.interrupt}, 8'h01);
    bif.interrupt_ack = 1'b1;
    step(1);
    bif.interrupt_ack = 1'b0;
    chk("hs_irq_ack", {7'h0, bif.interrupt}, 8'h00);
    step(2);
    chk("hs_no_retrig", {7'h0, bif.interrupt}, 8'h00);
    bif.address = 8'h03;
    bif.ren     = 1'b1;
    #1;
    chk("hs_rd_data", bif.data_out, 8'h01);
    step(1);
    bif.ren = 1'b0;
    chk_rd("hs_flags_clr", 8'h03, 8'h00);
    step(2);
    chk("hs_idle_irq", {7'h0, bif.interrupt}, 8'h00);

    // Masked edge on pin1: drop it first, then raise it.
    pins_in = 4'h9;
    step(6);
    chk("drop1_level", {4'h0, level_out}, 8'h09);
    chk_rd("drop1_flags", 8'h03, fall_flag1);
    bif.ren = 1'b1;
    step(1);
    bif.ren = 1'b0;
    pins_in = 4'hB;
    step(6);
    chk_rd("masked_flags", 8'h03, 8'h02);
    step(2);
    chk("masked_irq", {7'h0, bif.interrupt}, 8'h00);

    // Pin2 debounce completes on the same clock as a flag-clearing read.
    pins_in = 4'hF;
    step(5);
    bif.address = 8'h03;
    bif.ren     = 1'b1;
    step(1);
    bif.ren = 1'b0;
    chk("coll_level", {4'h0, level_out}, 8'h0F);
    chk_rd("coll_flags", 8'h03, 8'h04);

    // Falling edge on pin0.
    pins_in = 4'hE;
    step(6);
    chk("fall_level", {4'h0, level_out}, 8'h0E);
    chk_rd("fall_flags", 8'h03, fall_flags);
    step(1);
    chk("fall_irq", {7'h0, bif.interrupt}, fall_irq);

    // Widen the mask so flag2 requests; clearing mask in ASSERT keeps the request.
    bif.address  = 8'h04;
    bif.value_in = 8'h0F;
    bif.wen      = 1'b1;
    step(1);
    bif.wen = 1'b0;
    step(1);
    chk("mask_irq", {7'h0, bif.interrupt}, 8'h01);
    bif.value_in = 8'h00;
    bif.wen      = 1'b1;
    step(1);
    bif.wen = 1'b0;
    step(2);
    chk("mask_chg_hold", {7'h0, bif.interrupt}, 8'h01);

    // Asynchronous reset mid-handshake.
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_irq", {7'h0, bif.interrupt}, 8'h00);
    chk("midrst_level", {4'h0, level_out}, 8'h00);
    chk_rd("midrst_flags", 8'h03, 8'h00);
    step(1);
    rst = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
